// File: rtl/uart_pkg.sv
// Shared UART types: receive error flags, word length, FIFO trigger level,
// plus helpers for trigger depth and character frame length.
package uart_pkg;

    typedef struct packed {
        logic break_int;
        logic frame_err;
        logic parity_err;
    } rx_err_s;

    typedef enum logic [1:0] {
        WL_5 = 2'd0,
        WL_6 = 2'd1,
        WL_7 = 2'd2,
        WL_8 = 2'd3
    } word_len_e;

    typedef enum logic [1:0] {
        TRIG_1  = 2'd0,
        TRIG_4  = 2'd1,
        TRIG_8  = 2'd2,
        TRIG_14 = 2'd3
    } rx_trig_e;

    function automatic int trig_level(input rx_trig_e trig);
        case (trig)
            TRIG_1:  return 1;
            TRIG_4:  return 4;
            TRIG_8:  return 8;
            default: return 14;
        endcase
    endfunction

    // Start + stop + data bits + optional parity: 7..11 bit times.
    function automatic logic [3:0] frame_bits(input word_len_e wl, input logic parity_en);
        return 4'd7 + {2'b00, wl} + {3'b000, parity_en};
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO with flush; the head entry is visible on rdata
// without a read cycle. Capacity and overrun policy belong to the caller.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only observable once
    // count says they were written, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive buffer controller: FIFO/holding-register policy, overrun and
// error tracking, trigger-level and character-timeout interrupts.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   div_clk_en,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  uart_pkg::rx_err_s      rx_err,
    input  logic                   rd_en,
    input  logic                   lsr_rd,
    input  logic                   cfg_fifo_en,
    input  logic                   cfg_fifo_clr,
    input  uart_pkg::rx_trig_e     cfg_trig,
    input  uart_pkg::word_len_e    cfg_word_len,
    input  logic                   cfg_parity_en,
    output logic [7:0]             rd_data,
    output uart_pkg::rx_err_s      rd_err,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   data_ready,
    output logic                   overrun_err,
    output logic                   fifo_err,
    output logic                   trig_int,
    output logic                   timeout_int
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int EW = $bits(rx_err_s) + 8;

    logic [EW-1:0] head;
    rx_err_s       head_err;
    logic          fifo_en_q;
    logic          flush;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          overrun_set;
    logic          fifo_push;
    logic          fifo_pop;
    logic [LW-1:0] cap;
    logic [LW-1:0] trig_lvl;
    logic [LW-1:0] err_cnt;
    logic [9:0]    tmo_cnt;
    logic [9:0]    tmo_thr;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({rx_err, rx_data}),
        .rdata (head),
        .count (rx_level)
    );

    // A full holding register is overwritten (pop + push); a full FIFO drops.
    always_comb begin
        flush       = cfg_fifo_clr | (cfg_fifo_en != fifo_en_q);
        cap         = cfg_fifo_en ? LW'(DEPTH) : LW'(1);
        empty       = (rx_level == '0);
        full        = (rx_level >= cap);
        do_pop      = rd_en & ~empty & ~flush;
        overrun_set = rx_valid & ~flush & full & ~do_pop;
        fifo_push   = rx_valid & ~flush & ~(overrun_set & cfg_fifo_en);
        fifo_pop    = do_pop | (overrun_set & ~cfg_fifo_en);
        head_err    = rx_err_s'(head[EW-1:8]);
        trig_lvl    = (trig_level(cfg_trig) > DEPTH) ? LW'(DEPTH) : LW'(trig_level(cfg_trig));
        tmo_thr     = {frame_bits(cfg_word_len, cfg_parity_en), 6'b000000};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_en_q   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            fifo_en_q <= cfg_fifo_en;
            if (overrun_set)  overrun_err <= 1'b1;
            else if (lsr_rd)  overrun_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (flush) begin
            err_cnt <= '0;
        end else begin
            case ({fifo_push && (rx_err != '0), fifo_pop && (head_err != '0)})
                2'b10:   err_cnt <= err_cnt + LW'(1);
                2'b01:   err_cnt <= err_cnt - LW'(1);
                default: err_cnt <= err_cnt;
            endcase
        end
    end

    // Idle-time counter; any receive or read activity restarts the four-character window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (flush || rx_valid || do_pop || empty || !cfg_fifo_en) begin
            tmo_cnt <= '0;
        end else if (div_clk_en) begin
            tmo_cnt <= (tmo_cnt >= tmo_thr) ? tmo_thr : tmo_cnt + 10'd1;
        end
    end

    always_comb begin
        rd_data     = empty ? 8'h00 : head[7:0];
        rd_err      = empty ? '0 : head_err;
        data_ready  = ~empty;
        fifo_err    = (err_cnt != '0);
        trig_int    = cfg_fifo_en ? (rx_level >= trig_lvl) : ~empty;
        timeout_int = (tmo_cnt == tmo_thr) & ~empty;
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus queues expected head entries,
// a monitor compares them whenever the host pops.
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam rx_err_s NOERR = 3'b000;
    localparam rx_err_s PERR  = 3'b001;
    localparam rx_err_s FERR  = 3'b010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       div_clk_en = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    rx_err_s    rx_err = NOERR;
    logic       rd_en = 1'b0;
    logic       lsr_rd = 1'b0;
    logic       cfg_fifo_en = 1'b1;
    logic       cfg_fifo_clr = 1'b0;
    rx_trig_e   cfg_trig = TRIG_1;
    word_len_e  cfg_word_len = WL_8;
    logic       cfg_parity_en = 1'b0;
    logic [7:0] rd_data;
    rx_err_s    rd_err;
    logic [4:0] rx_level;
    logic       data_ready;
    logic       overrun_err;
    logic       fifo_err;
    logic       trig_int;
    logic       timeout_int;

    int tests = 0;
    int fails = 0;
    logic [10:0] exp_q[$];

    uart_rx_ctrl #(.DEPTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .div_clk_en    (div_clk_en),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_err        (rx_err),
        .rd_en         (rd_en),
        .lsr_rd        (lsr_rd),
        .cfg_fifo_en   (cfg_fifo_en),
        .cfg_fifo_clr  (cfg_fifo_clr),
        .cfg_trig      (cfg_trig),
        .cfg_word_len  (cfg_word_len),
        .cfg_parity_en (cfg_parity_en),
        .rd_data       (rd_data),
        .rd_err        (rd_err),
        .rx_level      (rx_level),
        .data_ready    (data_ready),
        .overrun_err   (overrun_err),
        .fifo_err      (fifo_err),
        .trig_int      (trig_int),
        .timeout_int   (timeout_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every host pop must present the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && rd_en) begin
            if (exp_q.size() == 0) begin
                check("pop_on_empty_ready", 32'(data_ready), 0);
                check("pop_on_empty_data", 32'(rd_data), 0);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check("pop_data", 32'(rd_data), 32'(e[7:0]));
                check("pop_err", 32'(rd_err), 32'(e[10:8]));
            end
        end
    end

    // Called at posedge+1; applies inputs for one cycle.
    task automatic drive(input logic v, input logic [7:0] d, input rx_err_s e,
                         input logic rd, input logic lsr);
        rx_valid = v;
        rx_data  = d;
        rx_err   = e;
        rd_en    = rd;
        lsr_rd   = lsr;
        @(posedge clk);
        #1;
        rx_valid     = 1'b0;
        rd_en        = 1'b0;
        lsr_rd       = 1'b0;
        cfg_fifo_clr = 1'b0;
    endtask

    task automatic push_ch(input logic [7:0] d, input rx_err_s e, input logic keep);
        if (keep) exp_q.push_back({e, d});
        drive(1'b1, d, e, 1'b0, 1'b0);
    endtask

    task automatic pop_ch();
        drive(1'b0, 8'h00, NOERR, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_level", 32'(rx_level), 0);
        check("rst_ready", 32'(data_ready), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        check("post_rst_level", 32'(rx_level), 0);
        check("post_rst_overrun", 32'(overrun_err), 0);
        check("post_rst_fifo_err", 32'(fifo_err), 0);
        check("post_rst_trig", 32'(trig_int), 0);
        check("post_rst_timeout", 32'(timeout_int), 0);
        check("post_rst_rd_err", 32'(rd_err), 0);

        // In-order FIFO traffic
        push_ch(8'h41, NOERR, 1'b1);
        push_ch(8'h42, NOERR, 1'b1);
        push_ch(8'h43, NOERR, 1'b1);
        check("abc_level3", 32'(rx_level), 3);
        check("abc_head", 32'(rd_data), 32'h41);
        pop_ch();
        check("abc_level2", 32'(rx_level), 2);
        pop_ch();
        check("abc_ready_before_last", 32'(data_ready), 1);
        pop_ch();
        check("abc_level0", 32'(rx_level), 0);
        check("abc_ready_fall", 32'(data_ready), 0);

        // Read of an empty FIFO is ignored
        pop_ch();
        check("underflow_level", 32'(rx_level), 0);

        // Fill to 16, 17th overruns
        for (int i = 0; i < 16; i++) push_ch(8'h10 + 8'(i), NOERR, 1'b1);
        check("full_level", 32'(rx_level), 16);
        check("full_no_overrun", 32'(overrun_err), 0);
        check("full_trig", 32'(trig_int), 1);
        push_ch(8'h20, NOERR, 1'b0);
        check("ovr_level", 32'(rx_level), 16);
        check("ovr_flag", 32'(overrun_err), 1);
        drive(1'b0, 8'h00, NOERR, 1'b0, 1'b1);
        check("ovr_lsr_clear", 32'(overrun_err), 0);

        // Full: simultaneous pop + push
        exp_q.push_back({NOERR, 8'h55});
        drive(1'b1, 8'h55, NOERR, 1'b1, 1'b0);
        check("popush_level", 32'(rx_level), 16);
        check("popush_no_overrun", 32'(overrun_err), 0);
        push_ch(8'h77, NOERR, 1'b0);
        check("ovr_again", 32'(overrun_err), 1);
        drive(1'b1, 8'h88, NOERR, 1'b0, 1'b1);
        check("ovr_lsr_same_cycle", 32'(overrun_err), 1);
        drive(1'b0, 8'h00, NOERR, 1'b0, 1'b1);
        check("ovr_lsr_clear2", 32'(overrun_err), 0);
        for (int i = 0; i < 16; i++) pop_ch();
        check("drain_level", 32'(rx_level), 0);

        // Trigger level 4 and 8N1 character timeout (64 * 10 = 640 ticks)
        cfg_trig = TRIG_4;
        push_ch(8'hA0, NOERR, 1'b1);
        push_ch(8'hA1, NOERR, 1'b1);
        check("trig4_two", 32'(trig_int), 0);
        div_clk_en = 1'b1;
        idle(639);
        check("tmo_639", 32'(timeout_int), 0);
        idle(1);
        check("tmo_640", 32'(timeout_int), 1);
        idle(5);
        check("tmo_hold", 32'(timeout_int), 1);
        div_clk_en = 1'b0;
        pop_ch();
        check("tmo_cleared_by_rd", 32'(timeout_int), 0);
        push_ch(8'hA2, NOERR, 1'b1);
        push_ch(8'hA3, NOERR, 1'b1);
        check("trig4_three", 32'(trig_int), 0);
        push_ch(8'hA4, NOERR, 1'b1);
        check("trig4_four", 32'(trig_int), 1);
        for (int i = 0; i < 4; i++) pop_ch();
        check("trig4_drained", 32'(trig_int), 0);

        // Error entry tracking
        push_ch(8'h31, NOERR, 1'b1);
        push_ch(8'h32, PERR, 1'b1);
        push_ch(8'h33, NOERR, 1'b1);
        check("ferr_set", 32'(fifo_err), 1);
        check("ferr_head_clean", 32'(rd_err), 0);
        pop_ch();
        check("ferr_still", 32'(fifo_err), 1);
        check("ferr_head_parity", 32'(rd_err.parity_err), 1);
        pop_ch();
        check("ferr_cleared", 32'(fifo_err), 0);
        check("ferr_head_clean2", 32'(rd_err.parity_err), 0);
        pop_ch();

        // Flush drops storage and a same-cycle receive
        push_ch(8'h91, NOERR, 1'b0);
        push_ch(8'h92, FERR, 1'b0);
        check("pre_flush_ferr", 32'(fifo_err), 1);
        cfg_fifo_clr = 1'b1;
        drive(1'b1, 8'h93, NOERR, 1'b0, 1'b0);
        check("flush_level", 32'(rx_level), 0);
        check("flush_ferr", 32'(fifo_err), 0);
        push_ch(8'h94, NOERR, 1'b1);
        check("post_flush_level", 32'(rx_level), 1);
        pop_ch();

        // Reset mid-operation
        push_ch(8'hE1, NOERR, 1'b0);
        push_ch(8'hE2, NOERR, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_level", 32'(rx_level), 0);
        check("midrst_rd_data", 32'(rd_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        check("midrst_after", 32'(data_ready), 0);

        // Holding-register mode
        cfg_fifo_en = 1'b0;
        idle(2);
        push_ch(8'hC1, NOERR, 1'b0);
        push_ch(8'hC2, NOERR, 1'b0);
        check("hold_data", 32'(rd_data), 32'hC2);
        check("hold_level", 32'(rx_level), 1);
        check("hold_overrun", 32'(overrun_err), 1);
        check("hold_trig", 32'(trig_int), 1);
        cfg_fifo_clr = 1'b1;
        drive(1'b0, 8'h00, NOERR, 1'b0, 1'b0);
        check("hold_clr_level", 32'(rx_level), 0);
        check("hold_clr_overrun_kept", 32'(overrun_err), 1);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
